// File: rtl/jtag_tap_ir.sv
// IEEE 1149.1 TAP controller with an IR_WIDTH instruction register, BYPASS, optional
// IDCODE (enabled by defining JTAG_IDCODE_EN) and one-hot selects for external user DRs.
module jtag_tap_ir #(
    parameter int          IR_WIDTH   = 4,
    parameter int          NUM_USER   = 2,
    parameter int          USER_BASE  = 2,
    parameter int          IDCODE_OP  = 1,
    parameter logic [31:0] IDCODE_VAL = 32'h0000_0001
) (
    input  logic                tck,
    input  logic                trst,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
    output logic                tdo_en,
    input  logic [NUM_USER-1:0] user_tdo,
    output logic [3:0]          state,
    output logic                capture_dr,
    output logic                shift_dr,
    output logic                update_dr,
    output logic                capture_ir,
    output logic                shift_ir,
    output logic                update_ir,
    output logic [IR_WIDTH-1:0] ir,
    output logic [NUM_USER-1:0] user_sel
);

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR_SCAN   = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR_SCAN   = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = {{(IR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IR_WIDTH-1:0] IR_ID_OP   = IR_WIDTH'(IDCODE_OP);
`ifdef JTAG_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] IR_RESET   = IR_ID_OP;
`else
    localparam logic [IR_WIDTH-1:0] IR_RESET   = {IR_WIDTH{1'b1}};
`endif

    tap_state_t          state_r;
    tap_state_t          next_state_s;
    logic [IR_WIDTH-1:0] ir_r;
    logic [IR_WIDTH-1:0] ir_shift_r;
    logic                bypass_r;
    logic                idcode_sel_s;
    logic                id_bit_s;
    logic                any_user_s;
    logic                user_bit_s;
    logic                bypass_sel_s;
    logic                tdo_s;
    logic                tdo_en_s;

    // Parameter sanity and one-hot user decode; bad opcode maps stop elaboration.
    if (IR_WIDTH < 2) begin : g_bad_width
        $error("jtag_tap_ir: IR_WIDTH must be at least 2");
    end
    if (IDCODE_VAL[0] != 1'b1) begin : g_bad_idcode
        $error("jtag_tap_ir: IDCODE_VAL bit 0 must be 1");
    end
    for (genvar g = 0; g < NUM_USER; g++) begin : g_user
        localparam int OPC = USER_BASE + g;
        if (OPC == IDCODE_OP || OPC >= (2 ** IR_WIDTH) - 1) begin : g_bad_opcode
            $error("jtag_tap_ir: user opcode collides with IDCODE or BYPASS");
        end
        assign user_sel[g] = (ir_r == IR_WIDTH'(OPC));
    end

    assign any_user_s   = |user_sel;
    assign user_bit_s   = |(user_tdo & user_sel);
    assign bypass_sel_s = !idcode_sel_s && !any_user_s;

`ifdef JTAG_IDCODE_EN
    logic [31:0] id_shift_r;

    assign idcode_sel_s = (ir_r == IR_ID_OP);
    assign id_bit_s     = id_shift_r[0];

    // IDCODE data register: capture the constant, shift right with tdi entering bit 31.
    always_ff @(posedge tck) begin
        if (trst) begin
            id_shift_r <= 32'h0000_0000;
        end else if (state_r == CAPTURE_DR && idcode_sel_s) begin
            id_shift_r <= IDCODE_VAL;
        end else if (state_r == SHIFT_DR && idcode_sel_s) begin
            id_shift_r <= {tdi, id_shift_r[31:1]};
        end else begin
            id_shift_r <= id_shift_r;
        end
    end
`else
    assign idcode_sel_s = 1'b0;
    assign id_bit_s     = 1'b0;
`endif

    // TAP state, instruction register and built-in shift registers.
    always_ff @(posedge tck) begin
        if (trst) begin
            state_r    <= TEST_LOGIC_RESET;
            ir_r       <= IR_RESET;
            ir_shift_r <= {IR_WIDTH{1'b0}};
            bypass_r   <= 1'b0;
        end else begin
            state_r <= next_state_s;
            case (state_r)
                TEST_LOGIC_RESET: ir_r       <= IR_RESET;
                CAPTURE_IR:       ir_shift_r <= IR_CAPTURE;
                SHIFT_IR:         ir_shift_r <= {tdi, ir_shift_r[IR_WIDTH-1:1]};
                UPDATE_IR:        ir_r       <= ir_shift_r;
                CAPTURE_DR:       bypass_r   <= bypass_sel_s ? 1'b0 : bypass_r;
                SHIFT_DR:         bypass_r   <= bypass_sel_s ? tdi : bypass_r;
                default:          ir_r       <= ir_r;
            endcase
        end
    end

    // Standard 1149.1 transition graph driven by tms.
    always_comb begin
        next_state_s = TEST_LOGIC_RESET;
        case (state_r)
            TEST_LOGIC_RESET: next_state_s = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    next_state_s = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   next_state_s = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       next_state_s = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         next_state_s = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         next_state_s = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         next_state_s = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         next_state_s = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        next_state_s = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   next_state_s = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       next_state_s = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         next_state_s = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         next_state_s = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         next_state_s = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         next_state_s = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        next_state_s = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          next_state_s = TEST_LOGIC_RESET;
        endcase
    end

    // Serial output mux; quiet outside the two shift states.
    always_comb begin
        tdo_s    = 1'b0;
        tdo_en_s = 1'b0;
        if (state_r == SHIFT_IR) begin
            tdo_en_s = 1'b1;
            tdo_s    = ir_shift_r[0];
        end else if (state_r == SHIFT_DR) begin
            tdo_en_s = 1'b1;
            if (idcode_sel_s) begin
                tdo_s = id_bit_s;
            end else if (any_user_s) begin
                tdo_s = user_bit_s;
            end else begin
                tdo_s = bypass_r;
            end
        end else begin
            tdo_s    = 1'b0;
            tdo_en_s = 1'b0;
        end
    end

    assign tdo        = tdo_s;
    assign tdo_en     = tdo_en_s;
    assign state      = state_r;
    assign ir         = ir_r;
    assign capture_dr = (state_r == CAPTURE_DR);
    assign shift_dr   = (state_r == SHIFT_DR);
    assign update_dr  = (state_r == UPDATE_DR);
    assign capture_ir = (state_r == CAPTURE_IR);
    assign shift_ir   = (state_r == SHIFT_IR);
    assign update_ir  = (state_r == UPDATE_IR);

endmodule
